// File: rtl/aes_inv_subbytes_iter.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE inverse S-box lanes walk the 16-byte state in place.
// Define AES_INV_SUBBYTES_SELFCHECK_EN to re-encrypt each lane against a shadow copy and flag mismatches on err.
module aes_inv_subbytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         err
);
  localparam int BPC       = BYTES_PER_CYCLE;
  localparam int NUM_STEPS = 16 / BPC;
  localparam int SW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("aes_inv_subbytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 InvSBox, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [10:0] idx;
    idx = {~a, 3'b000};
    return INV_SBOX[idx +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [SW-1:0]         step;
  logic [15:0][7:0]      work;
  logic [BPC-1:0][3:0]   pos;
  logic [BPC-1:0][7:0]   sb_in;
  logic [BPC-1:0][7:0]   sb_out;

  // Byte k of the state lives in work[15-k], so byte 0 stays the MSB byte.
  always_comb begin
    pos    = '0;
    sb_in  = '0;
    sb_out = '0;
    for (int b = 0; b < BPC; b++) begin
      pos[b]    = 4'(15 - (int'(step) * BPC + b));
      sb_in[b]  = work[pos[b]];
      sb_out[b] = inv_sbox(sb_in[b]);
    end
  end

  assign state_out = work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      step      <= '0;
      work      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= state_in;
            step     <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          for (int b = 0; b < BPC; b++) begin
            work[pos[b]] <= sb_out[b];
          end
          if (step == SW'(NUM_STEPS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            step <= step + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_INV_SUBBYTES_SELFCHECK_EN
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [10:0] idx;
    idx = {~a, 3'b000};
    return FWD_SBOX[idx +: 8];
  endfunction

  logic [15:0][7:0] shadow;
  logic             mismatch;

  always_comb begin
    mismatch = 1'b0;
    for (int b = 0; b < BPC; b++) begin
      if (fwd_sbox(sb_out[b]) != shadow[pos[b]]) mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      err    <= 1'b0;
    end else if (state == IDLE && in_valid && in_ready) begin
      shadow <= state_in;
      err    <= 1'b0;
    end else if (state == BUSY && mismatch) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_inv_subbytes_iter.sv
// Directed bench for aes_inv_subbytes_iter: default BPC=4 instance plus BPC=1/2/8/16 sweep instances.
module tb_aes_inv_subbytes_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         err;

  logic [3:0]   sw_in_valid;
  logic [3:0]   sw_in_ready;
  logic [3:0]   sw_out_valid;
  logic [3:0]   sw_err;
  logic         sw_out_ready;
  logic [127:0] sw_state_out [4];

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ROW0_IN  = 128'h637C777BF26B6FC53001672BFED7AB76;
  localparam logic [127:0] ROW0_OUT = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] ROW1_IN  = 128'hCA82C97DFA5947F0ADD4A2AF9CA472C0;
  localparam logic [127:0] ROW1_OUT = 128'h101112131415161718191A1B1C1D1E1F;

  always #5 clk = ~clk;

  aes_inv_subbytes_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out), .err(err)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int BPC_G = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(BPC_G)) u_dut (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]),
      .state_in(state_in), .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
      .state_out(sw_state_out[g]), .err(sw_err[g])
    );
  end

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_out !== 128'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b out=%h err=%b want 1 0 0 0", in_ready, out_valid, state_out, err);
    end
  endtask

  // Entered #1 after a clock edge with the DUT idle; returns the same way.
  task automatic test_vector(input logic [127:0] din, input logic [127:0] exp, input string name);
    int cnt;
    state_in = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL %s in_ready_busy got %b want 0", name, in_ready);
    end
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    checks++;
    if (cnt !== 4) begin
      errors++; $display("FAIL %s latency got %0d want 4", name, cnt);
    end
    checks++;
    if (state_out !== exp || err !== 1'b0) begin
      errors++; $display("FAIL %s result got %h err=%b want %h err=0", name, state_out, err, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release got vld=%b rdy=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    state_in = {16{8'h16}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = {16{8'hA5}};
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== {16{8'hFF}}) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b out=%h want 1 0 %h", i, out_valid, in_ready, state_out, {16{8'hFF}});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n_out;
    int c1;
    int c2;
    cyc = 0; n_out = 0; c1 = 0; c2 = 0;
    state_in  = ROW0_IN;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (n_out < 2 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) state_in = ROW1_IN;
      if (out_valid === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b in_ready_done got %b want 0", in_ready);
        end
        if (n_out == 0) begin
          c1 = cyc;
          checks++;
          if (state_out !== ROW0_OUT) begin
            errors++; $display("FAIL b2b first got %h want %h", state_out, ROW0_OUT);
          end
        end else begin
          c2 = cyc;
          in_valid = 1'b0;
          checks++;
          if (state_out !== ROW1_OUT) begin
            errors++; $display("FAIL b2b second got %h want %h", state_out, ROW1_OUT);
          end
        end
        n_out++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_out != 2 || (c2 - c1) < 5) begin
      errors++; $display("FAIL b2b spacing got n=%0d gap=%0d want n=2 gap>=5", n_out, c2 - c1);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    int cnt;
    state_in = ROW0_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== 128'h0) begin
      errors++; $display("FAIL midrst got vld=%b rdy=%b out=%h want 0 1 0", out_valid, in_ready, state_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_no_pulse got %0d pulses want 0", seen);
    end
    state_in = {16{8'hED}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    checks++;
    if (cnt !== 4 || state_out !== {16{8'h53}}) begin
      errors++; $display("FAIL midrst_recover got lat=%0d out=%h want 4 %h", cnt, state_out, {16{8'h53}});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    int exp_lat [4] = '{16, 8, 2, 1};
    for (int j = 0; j < 4; j++) begin
      int cnt;
      checks++;
      if (sw_in_ready[j] !== 1'b1) begin
        errors++; $display("FAIL sweep%0d in_ready got %b want 1", j, sw_in_ready[j]);
      end
      state_in = ROW0_IN;
      sw_in_valid[j] = 1'b1;
      @(posedge clk); #1;
      sw_in_valid[j] = 1'b0;
      cnt = 0;
      while (sw_out_valid[j] !== 1'b1 && cnt < 40) begin
        @(posedge clk); #1; cnt++;
      end
      checks++;
      if (cnt !== exp_lat[j]) begin
        errors++; $display("FAIL sweep%0d latency got %0d want %0d", j, cnt, exp_lat[j]);
      end
      checks++;
      if (sw_state_out[j] !== ROW0_OUT || sw_err[j] !== 1'b0) begin
        errors++; $display("FAIL sweep%0d result got %h err=%b want %h err=0", j, sw_state_out[j], sw_err[j], ROW0_OUT);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef AES_INV_SUBBYTES_SELFCHECK_EN
  task automatic test_selfcheck_fault();
    int cnt;
    force dut.sb_out = '0;
    state_in = 128'h0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    release dut.sb_out;
    checks++;
    if (out_valid !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL selfcheck_fault got vld=%b err=%b want 1 1", out_valid, err);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    state_in     = 128'h0;
    sw_in_valid  = 4'b0;
    sw_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_vector(ROW0_IN, ROW0_OUT, "row0");
    test_vector(ROW1_IN, ROW1_OUT, "row1");
    test_vector(128'h0, {16{8'h52}}, "zeros");
    test_vector({16{8'h16}}, {16{8'hFF}}, "all16");
    test_vector({16{8'hED}}, {16{8'h53}}, "allED");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
`ifdef AES_INV_SUBBYTES_SELFCHECK_EN
    test_selfcheck_fault();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
